video_pattern_gen: RTL
======================

// Module: video_pattern_gen
// PURPOSE
//  Parametrised video timing + test-pattern source for the encoder path; successor to the fixed 640x480 gradient source.
//  Generates HSYNC/VSYNC/DE for any raster and one of four runtime-selectable patterns: moving gradient, 8 colour bars, checkerboard, solid colour.
//  All outputs are registered and mutually aligned. A frame counter and a start-of-frame pulse are provided for downstream encoders.
// PARAMETERS
//  H_ACTIVE 640  active pixels per line
//  H_FP     16   horizontal front porch (clocks)
//  H_SYNC   96   hsync width (clocks)
//  H_BP     48   horizontal back porch (clocks)
//  V_ACTIVE 480  active lines per frame
//  V_FP     10   vertical front porch (lines)
//  V_SYNC   2    vsync width (lines)
//  V_BP     33   vertical back porch (lines)
//  HS_POL   1    hsync asserted level (1 = active-high)
//  VS_POL   1    vsync asserted level (1 = active-high)
//  CW       8    bits per colour channel
//  CNT_W    12   h/v counter width; must satisfy H_TOTAL, V_TOTAL <= 2**CNT_W
//  CHK_LOG2 5    log2 of checkerboard square size (pixels)
// PORTS
//  clk        in   1      pixel clock
//  rst        in   1      synchronous active-high reset
//  mode       in   2      pattern select: 0 gradient, 1 bars, 2 checker, 3 solid
//  solid_rgb  in   3*CW   {r,g,b} for mode 3
//  hsync      out  1      horizontal sync, level per HS_POL
//  vsync      out  1      vertical sync, level per VS_POL
//  de         out  1      data enable (active region)
//  red        out  CW     red channel
//  green      out  CW     green channel
//  blue       out  CW     blue channel
//  sof        out  1      1-clock pulse coincident with pixel (0,0)
//  frame_cnt  out  CW     completed-frame count, wraps 2**CW-1 -> 0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h counts 0..H_TOTAL-1; v increments on h wrap, counts 0..V_TOTAL-1.
//  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), full lines.
//  - de = (h < H_ACTIVE) && (v < V_ACTIVE). Every output registered: latency 1 clock from counter state to all pins, all pins aligned.
//  - rst (sync, priority over all): h=v=0, frame_cnt=0, mode_q=0, solid_q=0; outputs de=0, sof=0, rgb=0, hsync=~HS_POL, vsync=~VS_POL.
//    The first clock after rst deasserts presents pixel (0,0): de=1, sof=1. Reset mid-frame aborts the frame; no partial state is kept.
//  - Frame boundary = clock with h==H_TOTAL-1 && v==V_TOTAL-1. There: frame_cnt+=1 (mod 2**CW); mode_q<=mode; solid_q<=solid_rgb.
//    mode/solid_rgb changes mid-frame have no visible effect until the next frame.
//  - Pattern (x=h, y=v, arithmetic mod 2**CW, low CW bits of counters):
//    0 gradient: r=x+frame_cnt, g=y+frame_cnt, b=x+y.
//    1 bars: BAR_W=H_ACTIVE/8 (integer); index = min(x/BAR_W,7), via a bar-position counter (no divider);
//      the remainder pixels join bar 7. Order: white, yellow, cyan, green, magenta, red, blue, black; full-scale = all ones.
//    2 checker: white if x[CHK_LOG2]^y[CHK_LOG2]==0, else black.
//    3 solid: {r,g,b}=solid_q.
//  - rgb forced to 0 whenever de=0, in every mode.
//  - sof asserted only for pixel (0,0) of each frame; never during blanking.
// STRUCTURE
//  - Package video_pattern_pkg: mode encodings (PAT_GRADIENT..PAT_SOLID), bar colour table, default 640x480 timing constants.
//  - Sub-module video_timing_ctr: h/v counters, frame-boundary strobe, combinational sync/de decode (reusable by other sources).
//  - Top: mode/solid latches, frame_cnt, bar counter, pattern mux, output register stage.
// TESTING
//  1. rst held 3 clocks, mode=0 -> all outputs at reset values; 1st clock after release: de=1, sof=1, rgb=000000.
//  2. Defaults, run 2 frames -> 800-clock lines; hsync high 96 clocks beginning 656 clocks after de rises; vsync high 1600 clocks;
//     420000 clocks per frame; 307200 de cycles and exactly 1 sof per frame.
//  3. mode=1 applied at line 100 -> unchanged this frame; next frame x=0 FFFFFF, x=80 FFFF00, x=560 000000, x=639 000000.
//  4. mode=2 -> (0,0) FFFFFF, (32,0) 000000, (32,32) FFFFFF; mode=3 with solid_rgb=123456 -> every active pixel 123456, blanking 000000.
//  5. mode=0, frame_cnt=3 -> pixel (10,20) = r 0D, g 17, b 1E; tiny raster (H_ACTIVE=4, V_ACTIVE=2) 256 frames -> frame_cnt 255->0.
//  6. rst pulsed at h=300, v=5 -> next clock reset values; after release counting restarts at (0,0), frame_cnt=0, mode_q=0.

Source files
------------

// File: rtl/video_pattern_pkg.sv
// rtl/video_pattern_pkg.sv - pattern mode encodings, colour-bar table and default 640x480 timing
package video_pattern_pkg;

   typedef enum logic [1:0] {
      PAT_GRADIENT = 2'd0,
      PAT_BARS     = 2'd1,
      PAT_CHECKER  = 2'd2,
      PAT_SOLID    = 2'd3
   } pat_mode_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // {r,g,b} full-scale flags; index 0 is the left-most bar (white), index 7 black.
   localparam logic [7:0][2:0] BAR_TABLE = {
      3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
   };

endpackage

// File: rtl/video_pattern_gen_if.sv
// rtl/video_pattern_gen_if.sv - registered video output bundle from the pattern source
interface video_pattern_gen_if #(
   parameter int CW = 8
);
   logic          hsync;
   logic          vsync;
   logic          de;
   logic          sof;
   logic [CW-1:0] red;
   logic [CW-1:0] green;
   logic [CW-1:0] blue;
   logic [CW-1:0] frame_cnt;

   modport master (output hsync, vsync, de, sof, red, green, blue, frame_cnt);
   modport slave  (input  hsync, vsync, de, sof, red, green, blue, frame_cnt);
endinterface

// File: rtl/video_timing_ctr.sv
// rtl/video_timing_ctr.sv - raster h/v counters with combinational sync/de decode and frame strobe
module video_timing_ctr
   import video_pattern_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int CNT_W    = 12
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output logic             de,
   output logic             hs_act,
   output logic             vs_act,
   output logic             line_end,
   output logic             frame_end
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   always_ff @(posedge clk) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (line_end) begin
         h <= '0;
         v <= frame_end ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   always_comb begin
      line_end  = int'(h) == H_TOTAL - 1;
      frame_end = line_end && (int'(v) == V_TOTAL - 1);
      de        = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
      hs_act    = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
      vs_act    = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
   end

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - runtime-selectable test-pattern source with registered, aligned video outputs
module video_pattern_gen
   import video_pattern_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int CW       = 8,
   parameter int CNT_W    = 12,
   parameter int CHK_LOG2 = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mode,
   input  logic [3*CW-1:0]     solid_rgb,
   video_pattern_gen_if.master vid
);
   // Narrow rasters still get a 1-pixel bar so the counter compare stays meaningful.
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   logic             de_c;
   logic             hs_act;
   logic             vs_act;
   logic             line_end;
   logic             frame_end;

   video_timing_ctr #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .CNT_W    (CNT_W)
   ) u_timing (
      .clk       (clk),
      .rst       (rst),
      .h         (h),
      .v         (v),
      .de        (de_c),
      .hs_act    (hs_act),
      .vs_act    (vs_act),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   pat_mode_t       mode_q;
   logic [3*CW-1:0] solid_q;
   logic [CW-1:0]   frame_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= PAT_GRADIENT;
         solid_q <= '0;
         frame_q <= '0;
      end else if (frame_end) begin
         mode_q  <= pat_mode_t'(mode);
         solid_q <= solid_rgb;
         frame_q <= frame_q + 1'b1;
      end
   end

   // Bar position tracks h alongside the timing counter; bar 7 absorbs the remainder pixels.
   logic [CNT_W-1:0] bar_cnt;
   logic [2:0]       bar_idx;

   always_ff @(posedge clk) begin
      if (rst || line_end) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (bar_idx != 3'd7) begin
         if (int'(bar_cnt) == BAR_W - 1) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_cnt <= bar_cnt + 1'b1;
         end
      end
   end

   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic [CW-1:0] r_c;
   logic [CW-1:0] g_c;
   logic [CW-1:0] b_c;
   logic [2:0]    bar_rgb;
   logic          chk_white;

   always_comb begin
      x         = CW'(h);
      y         = CW'(v);
      bar_rgb   = BAR_TABLE[bar_idx];
      chk_white = ~(h[CHK_LOG2] ^ v[CHK_LOG2]);
      r_c       = '0;
      g_c       = '0;
      b_c       = '0;
      if (de_c) begin
         case (mode_q)
            PAT_GRADIENT: begin
               r_c = x + frame_q;
               g_c = y + frame_q;
               b_c = x + y;
            end
            PAT_BARS: begin
               r_c = {CW{bar_rgb[2]}};
               g_c = {CW{bar_rgb[1]}};
               b_c = {CW{bar_rgb[0]}};
            end
            PAT_CHECKER: begin
               r_c = {CW{chk_white}};
               g_c = {CW{chk_white}};
               b_c = {CW{chk_white}};
            end
            default: {r_c, g_c, b_c} = solid_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vid.hsync     <= ~HS_POL;
         vid.vsync     <= ~VS_POL;
         vid.de        <= 1'b0;
         vid.sof       <= 1'b0;
         vid.red       <= '0;
         vid.green     <= '0;
         vid.blue      <= '0;
         vid.frame_cnt <= '0;
      end else begin
         vid.hsync     <= hs_act ? HS_POL : ~HS_POL;
         vid.vsync     <= vs_act ? VS_POL : ~VS_POL;
         vid.de        <= de_c;
         vid.sof       <= (h == '0) && (v == '0);
         vid.red       <= r_c;
         vid.green     <= g_c;
         vid.blue      <= b_c;
         vid.frame_cnt <= frame_q;
      end
   end

endmodule
